irq_sequencer: RTL



---
 rtl/irq_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/irq_sequencer.sv
// Interrupt entry/exit sequencer: latches edge requests, applies mask and fixed
// priority, supports nesting, and drives the stack/vector control lines.
module irq_sequencer #(
    parameter int unsigned          N_IRQ      = 4,
    parameter int unsigned          DATA_W     = 16,
    parameter int unsigned          NEST_DEPTH = 2,
    parameter logic [DATA_W-1:0]    VEC_BASE   = 'hFF00,
    parameter logic [N_IRQ-1:0]     MASK_RESET = '1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [N_IRQ-1:0]                  irq_req,
    input  logic                              mask_wr,
    input  logic [N_IRQ-1:0]                  mask_data,
    input  logic                              boundary,
    input  logic                              rti_req,
    input  logic [DATA_W-1:0]                 this_pc,
    input  logic [DATA_W-1:0]                 sr_in,
    input  logic [DATA_W-1:0]                 mem_rdata,
    output logic                              busy,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic                              mem_addr_is_sp,
    output logic [DATA_W-1:0]                 vec_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    output logic                              sp_inc,
    output logic                              sp_dec,
    output logic                              set_pc,
    output logic [DATA_W-1:0]                 pc_load,
    output logic                              set_sr,
    output logic [N_IRQ-1:0]                  irq_ack,
    output logic [$clog2(N_IRQ)-1:0]          active_id,
    output logic [$clog2(NEST_DEPTH+1)-1:0]   nest_level,
    output logic                              rti_underflow
);

    localparam int unsigned IdW  = $clog2(N_IRQ);
    localparam int unsigned LvlW = $clog2(NEST_DEPTH + 1);

    typedef enum logic [3:0] {
        StIdle, StPushPc, StIncPc, StPushSr, StIncSr, StVecAddr, StVecLoad,
        StDecSr, StSrAddr, StSrLoad, StDecPc, StPcAddr, StPcLoad
    } state_e;

    state_e            state_q, state_d;
    logic [N_IRQ-1:0]  irq_prev_q, pending_q, pending_d, mask_q, cand;
    logic [IdW-1:0]    win, win_q, active_id_q, active_id_d;
    logic [IdW-1:0]    stack_q [NEST_DEPTH];
    logic [IdW-1:0]    stack_d [NEST_DEPTH];
    logic [LvlW-1:0]   nest_q, nest_d;
    logic [DATA_W-1:0] pc_q, sr_q;
    logic              underflow_q, underflow_d, accept, capture;

    // Highest-priority enabled pending request and whether it may preempt.
    always_comb begin
        cand = pending_q & mask_q;
        win  = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (cand[i]) win = IdW'(i);
        end
        accept = (|cand) && ((nest_q == '0) ||
                 ((win < active_id_q) && (nest_q < LvlW'(NEST_DEPTH))));
    end

    // Next-state: RTI wins over a simultaneous boundary; both ignored while busy.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rti_req) begin
                    state_d = StDecSr;
                end else if (boundary && accept) begin
                    state_d = StPushPc;
                    capture = 1'b1;
                end
            end
            StPushPc:  state_d = StIncPc;
            StIncPc:   state_d = StPushSr;
            StPushSr:  state_d = StIncSr;
            StIncSr:   state_d = StVecAddr;
            StVecAddr: state_d = StVecLoad;
            StVecLoad: state_d = StIdle;
            StDecSr:   state_d = StSrAddr;
            StSrAddr:  state_d = StSrLoad;
            StSrLoad:  state_d = StDecPc;
            StDecPc:   state_d = StPcAddr;
            StPcAddr:  state_d = StPcLoad;
            StPcLoad:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Control-line decode from the registered state.
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr_is_sp = 1'b0;
        vec_addr       = '0;
        mem_wdata      = '0;
        sp_inc         = 1'b0;
        sp_dec         = 1'b0;
        set_pc         = 1'b0;
        pc_load        = '0;
        set_sr         = 1'b0;
        irq_ack        = '0;
        unique case (state_q)
            StPushPc: begin mem_write = 1'b1; mem_addr_is_sp = 1'b1; mem_wdata = pc_q; end
            StIncPc:  sp_inc = 1'b1;
            StPushSr: begin mem_write = 1'b1; mem_addr_is_sp = 1'b1; mem_wdata = sr_q; end
            StIncSr:  sp_inc = 1'b1;
            StVecAddr: begin
                mem_read = 1'b1;
                vec_addr = VEC_BASE + DATA_W'(win_q);  // wraps modulo 2^DATA_W
            end
            StVecLoad: begin
                set_pc  = 1'b1;
                pc_load = mem_rdata;
                for (int i = 0; i < int'(N_IRQ); i++) irq_ack[i] = (int'(win_q) == i);
            end
            StDecSr:  sp_dec = 1'b1;
            StSrAddr: begin mem_read = 1'b1; mem_addr_is_sp = 1'b1; end
            StSrLoad: begin set_sr = 1'b1; mem_addr_is_sp = 1'b1; end
            StDecPc:  sp_dec = 1'b1;
            StPcAddr: begin mem_read = 1'b1; mem_addr_is_sp = 1'b1; end
            StPcLoad: begin set_pc = 1'b1; pc_load = mem_rdata; end
            default: ;
        endcase
    end

    // Pending latch, level stack push/pop and underflow flag.
    always_comb begin
        // A fresh edge in the ack cycle keeps the request pending.
        pending_d   = (pending_q & ~irq_ack) | (irq_req & ~irq_prev_q);
        nest_d      = nest_q;
        active_id_d = active_id_q;
        underflow_d = underflow_q;
        stack_d     = stack_q;
        if (state_q == StVecLoad) begin
            for (int i = 0; i < int'(NEST_DEPTH); i++) begin
                if (i == int'(nest_q)) stack_d[i] = win_q;
            end
            nest_d      = nest_q + LvlW'(1);
            active_id_d = win_q;
        end else if (state_q == StPcLoad) begin
            if (nest_q != '0) begin
                nest_d      = nest_q - LvlW'(1);
                active_id_d = '0;
                for (int i = 0; i < int'(NEST_DEPTH); i++) begin
                    if (i + 2 == int'(nest_q)) active_id_d = stack_q[i];
                end
            end else begin
                underflow_d = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            irq_prev_q  <= '0;
            pending_q   <= '0;
            mask_q      <= MASK_RESET;
            win_q       <= '0;
            pc_q        <= '0;
            sr_q        <= '0;
            nest_q      <= '0;
            active_id_q <= '0;
            underflow_q <= 1'b0;
            for (int i = 0; i < int'(NEST_DEPTH); i++) stack_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            irq_prev_q  <= irq_req;
            pending_q   <= pending_d;
            nest_q      <= nest_d;
            active_id_q <= active_id_d;
            underflow_q <= underflow_d;
            stack_q     <= stack_d;
            if (mask_wr) mask_q <= mask_data;
            if (capture) begin
                win_q <= win;
                pc_q  <= this_pc;
                sr_q  <= sr_in;
            end
        end
    end

    assign busy          = (state_q != StIdle);
    assign active_id     = active_id_q;
    assign nest_level    = nest_q;
    assign rti_underflow = underflow_q;

endmodule
